// File: rtl/updown_counter_param.sv
// updown_counter_param: prescaled up/down counter with wrap or saturate at limits
module updown_counter_param #(
  parameter int WIDTH    = 4,
  parameter int MAX_VAL  = 2**WIDTH-1,
  parameter int SATURATE = 0,
  parameter int DIV      = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             at_max,
  output logic             at_zero,
  output logic             wrap
);
  localparam int PW = DIV > 1 ? $clog2(DIV) : 1;
  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_VAL);
  localparam logic [PW-1:0] PLAST = PW'(DIV-1);
  localparam bit SAT = SATURATE != 0;
  logic [WIDTH-1:0] r_count;
  logic [PW-1:0]    r_presc;
  logic             r_wrap;
  logic             w_tick;
  logic             w_limit;
  logic [WIDTH-1:0] w_step;
  assign w_tick  = en && r_presc == PLAST;
  assign w_limit = up ? r_count == MAXV : r_count == '0;
  // at a limit: saturate holds, wrap jumps to the opposite limit
  assign w_step  = w_limit ? (SAT ? r_count : (up ? '0 : MAXV))
                           : (up ? r_count + 1'b1 : r_count - 1'b1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_presc <= '0;
      r_wrap  <= 1'b0;
    end else if (clr) begin
      r_count <= '0;
      r_presc <= '0;
      r_wrap  <= 1'b0;
    end else if (load) begin
      r_count <= load_val > MAXV ? MAXV : load_val;
      r_presc <= '0;
      r_wrap  <= 1'b0;
    end else begin
      r_wrap <= w_tick && w_limit && !SAT;
      if (en) r_presc <= w_tick ? '0 : r_presc + 1'b1;
      if (w_tick) r_count <= w_step;
    end
  end
  assign count   = r_count;
  assign wrap    = r_wrap;
  assign at_max  = r_count == MAXV;
  assign at_zero = r_count == '0;
endmodule

// File: tb/tb_updown_counter_param.sv
// tb_updown_counter_param: directed checks over wrap, saturate, prescale and 1-bit variants
module tb_updown_counter_param;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic en = 1'b0, up = 1'b0, clr = 1'b0, load = 1'b0;
  logic [3:0] load_val = '0;
  logic [3:0] a_count, s_count, d_count;
  logic [0:0] b_count;
  logic a_max, a_zero, a_wrap, s_max, s_zero, s_wrap, d_max, d_zero, d_wrap, b_max, b_zero, b_wrap;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  updown_counter_param #(.WIDTH(4), .MAX_VAL(9), .SATURATE(0), .DIV(1)) u_a (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .clr(clr), .load(load), .load_val(load_val),
    .count(a_count), .at_max(a_max), .at_zero(a_zero), .wrap(a_wrap));
  updown_counter_param #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1), .DIV(1)) u_s (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .clr(clr), .load(load), .load_val(load_val),
    .count(s_count), .at_max(s_max), .at_zero(s_zero), .wrap(s_wrap));
  updown_counter_param #(.WIDTH(4), .MAX_VAL(9), .SATURATE(0), .DIV(4)) u_d (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .clr(clr), .load(load), .load_val(load_val),
    .count(d_count), .at_max(d_max), .at_zero(d_zero), .wrap(d_wrap));
  updown_counter_param #(.WIDTH(1), .MAX_VAL(1), .SATURATE(0), .DIV(1)) u_b (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .clr(clr), .load(load), .load_val(load_val[0]),
    .count(b_count), .at_max(b_max), .at_zero(b_zero), .wrap(b_wrap));

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2;
    check("rst_count", a_count, 0);
    check("rst_zero", a_zero, 1);
    check("rst_max", a_max, 0);
    check("rst_wrap", a_wrap, 0);
    #9 rst_n = 1'b1;
    en = 1'b1;
    up = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      check($sformatf("up_count%0d", k), a_count, k % 10);
      check($sformatf("up_wrap%0d", k), a_wrap, k == 10 ? 1 : 0);
      check($sformatf("sat_count%0d", k), s_count, k < 9 ? k : 9);
      check($sformatf("sat_wrap%0d", k), s_wrap, 0);
      check($sformatf("b_count%0d", k), b_count, k % 2);
      check($sformatf("b_wrap%0d", k), b_wrap, k % 2 == 0 ? 1 : 0);
      if (k <= 8) check($sformatf("div_count%0d", k), d_count, k / 4);
    end
    check("sat_at_max", s_max, 1);
    // u_d presc is 0 here; two enabled cycles, two idle, then two more
    step(); step();
    check("div_pre", d_count, 3);
    en = 1'b0;
    step(); step();
    check("div_hold", d_count, 3);
    check("a_hold", a_count, 4);
    check("a_hold_wrap", a_wrap, 0);
    en = 1'b1;
    step();
    check("div_delay", d_count, 3);
    step();
    check("div_step", d_count, 4);
    check("a_resume", a_count, 6);
    clr = 1'b1; load = 1'b1; load_val = 4'd7;
    step();
    check("clr_pri_a", a_count, 0);
    check("clr_pri_d", d_count, 0);
    clr = 1'b0; load = 1'b0; up = 1'b0;
    step();
    check("dn_wrap_count", a_count, 9);
    check("dn_wrap_pulse", a_wrap, 1);
    check("dn_at_max", a_max, 1);
    check("dn_not_zero", a_zero, 0);
    check("dn_sat_count", s_count, 0);
    check("dn_sat_wrap", s_wrap, 0);
    check("dn_sat_zero", s_zero, 1);
    en = 1'b0;
    step();
    check("wrap_fall", a_wrap, 0);
    check("idle_count", a_count, 9);
    load = 1'b1; load_val = 4'd13;
    step();
    check("load_clamp", a_count, 9);
    load_val = 4'd2;
    step();
    check("load_val", a_count, 2);
    load = 1'b0; en = 1'b1; up = 1'b0;
    step();
    check("dn1", a_count, 1);
    step();
    check("dn0", a_count, 0);
    check("dn0_wrap", a_wrap, 0);
    step();
    check("dn_under", a_count, 9);
    check("dn_under_wrap", a_wrap, 1);
    en = 1'b0; load = 1'b1; load_val = 4'd5;
    step();
    check("load5", a_count, 5);
    check("load_clr_wrap", a_wrap, 0);
    load = 1'b0; en = 1'b1; up = 1'b1;
    step();
    check("pre_rst", a_count, 6);
    en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_count", a_count, 0);
    check("async_rst_zero", a_zero, 1);
    check("async_rst_max", a_max, 0);
    check("async_rst_wrap", a_wrap, 0);
    #1 rst_n = 1'b1;
    en = 1'b1;
    step();
    check("post_rst", a_count, 1);
    step(); step();
    check("presc_discard3", d_count, 0);
    step();
    check("presc_discard4", d_count, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
